// File: rtl/uart_tx_mmio_if.sv
// ---------------------------------------------------------------------------
// uart_tx_mmio_if
//
// Purpose: groups the data-memory read/write port signals that connect the
// core's MEM stage to the memory-mapped UART transmitter.
//
// Signals:
//   data_rd_addr  core read address (32)
//   data_rd_data  status word or zero, combinational (32)
//   rd_hit        read address falls inside the UART window (1)
//   data_wr       write size from the core; nonzero means write strobe (2)
//   data_wr_addr  core write address (32)
//   data_wr_data  core write data (32)
//   wr_hit        write strobe active and address inside the window (1)
//
// Modports:
//   master  the core side (drives addresses, strobes and write data)
//   slave   the UART side (drives read data and the hit flags)
// ---------------------------------------------------------------------------
interface uart_tx_mmio_if;
    logic [31:0] data_rd_addr;
    logic [31:0] data_rd_data;
    logic        rd_hit;
    logic [1:0]  data_wr;
    logic [31:0] data_wr_addr;
    logic [31:0] data_wr_data;
    logic        wr_hit;

    modport master (
        output data_rd_addr,
        output data_wr,
        output data_wr_addr,
        output data_wr_data,
        input  data_rd_data,
        input  rd_hit,
        input  wr_hit
    );

    modport slave (
        input  data_rd_addr,
        input  data_wr,
        input  data_wr_addr,
        input  data_wr_data,
        output data_rd_data,
        output rd_hit,
        output wr_hit
    );
endinterface

// File: rtl/uart_tx_mmio.sv
// ---------------------------------------------------------------------------
// uart_tx_mmio
//
// Purpose: memory-mapped 8N1 UART transmitter. Core writes to TXDATA push a
// byte into a FIFO; a transmit FSM pops bytes and serialises them LSB first
// on tx. STATUS can be polled for FIFO space, line activity and a sticky
// overflow flag (cleared by writing bit3 of STATUS).
//
// Register map:
//   BASE_ADDR      TXDATA  write: push data[7:0]; read: 0
//   BASE_ADDR + 4  STATUS  read : {16'b0, count[7:0], 4'b0, ovf, busy, empty, full}
//                          write: data[3]=1 clears overflow
//
// Ports:
//   clk  single clock, rising edge
//   rst  asynchronous, active-high reset
//   bus  data-memory port (slave modport of uart_tx_mmio_if)
//   tx   serial output, idle high, driven from a register
//
// Parameters:
//   BASE_ADDR     byte address of TXDATA
//   CLKS_PER_BIT  clock cycles per serial bit (>= 2)
//   FIFO_DEPTH    FIFO entries (power of 2, <= 128)
// ---------------------------------------------------------------------------
module uart_tx_mmio #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic           clk,
    input  logic           rst,
    uart_tx_mmio_if.slave  bus,
    output logic           tx
);

    localparam int unsigned   AW          = $clog2(FIFO_DEPTH);
    localparam int unsigned   CW          = AW + 1;
    localparam int unsigned   BW          = $clog2(CLKS_PER_BIT);
    localparam logic [31:0]   STATUS_ADDR = BASE_ADDR + 32'd4;
    localparam logic [CW-1:0] FULL_COUNT  = CW'(FIFO_DEPTH);
    localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    // -----------------------------------------------------------------------
    // Address decode
    // -----------------------------------------------------------------------
    logic wr_any;
    logic wr_txdata;
    logic wr_status;
    logic rd_status;

    assign wr_any      = (bus.data_wr != 2'b00);
    assign wr_txdata   = wr_any && (bus.data_wr_addr == BASE_ADDR);
    assign wr_status   = wr_any && (bus.data_wr_addr == STATUS_ADDR);
    assign bus.wr_hit  = wr_txdata || wr_status;

    assign rd_status   = (bus.data_rd_addr == STATUS_ADDR);
    assign bus.rd_hit  = (bus.data_rd_addr == BASE_ADDR) || rd_status;

    // Only the low byte (and bit3 for STATUS) of write data is meaningful.
    logic unused_wr_data;
    assign unused_wr_data = ^bus.data_wr_data[31:8];

    // -----------------------------------------------------------------------
    // FIFO
    // -----------------------------------------------------------------------
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          overflow;

    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);

    // A pop in the same cycle frees a slot, so a write to a full FIFO is
    // still accepted when the transmitter is taking a byte.
    assign push  = wr_txdata && (!full || pop);

    // Storage needs no reset: pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= bus.data_wr_data[7:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wptr <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            // Set and clear target different addresses, so they never
            // coincide in one cycle.
            if (wr_txdata && full && !pop) begin
                overflow <= 1'b1;
            end else if (wr_status && bus.data_wr_data[3]) begin
                overflow <= 1'b0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Transmit FSM
    // -----------------------------------------------------------------------
    state_t        state;
    state_t        state_next;
    logic [BW-1:0] baud;
    logic [BW-1:0] baud_next;
    logic [2:0]    bit_idx;
    logic [2:0]    bit_idx_next;
    logic [7:0]    shift;
    logic [7:0]    shift_next;
    logic          tx_next;
    logic          baud_done;

    assign baud_done = (baud == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx      <= 1'b1;
        end else begin
            state   <= state_next;
            baud    <= baud_next;
            bit_idx <= bit_idx_next;
            shift   <= shift_next;
            tx      <= tx_next;
        end
    end

    always_comb begin
        state_next   = state;
        baud_next    = baud;
        bit_idx_next = bit_idx;
        shift_next   = shift;
        pop          = 1'b0;
        tx_next      = 1'b1;

        case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    shift_next = mem[rptr];
                    baud_next  = BAUD_RELOAD;
                    state_next = S_START;
                end
            end

            S_START: begin
                if (baud_done) begin
                    baud_next    = BAUD_RELOAD;
                    bit_idx_next = '0;
                    state_next   = S_DATA;
                end else begin
                    baud_next = baud - BW'(1);
                end
            end

            S_DATA: begin
                if (baud_done) begin
                    baud_next = BAUD_RELOAD;
                    if (bit_idx == 3'd7) begin
                        state_next = S_STOP;
                    end else begin
                        shift_next   = shift >> 1;
                        bit_idx_next = bit_idx + 3'd1;
                    end
                end else begin
                    baud_next = baud - BW'(1);
                end
            end

            S_STOP: begin
                if (baud_done) begin
                    // Chain straight into the next start bit when more data
                    // is waiting, keeping back-to-back frames contiguous.
                    if (!empty) begin
                        pop        = 1'b1;
                        shift_next = mem[rptr];
                        baud_next  = BAUD_RELOAD;
                        state_next = S_START;
                    end else begin
                        state_next = S_IDLE;
                    end
                end else begin
                    baud_next = baud - BW'(1);
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase

        // tx is registered from the upcoming state so the line changes on
        // the same edge as the state and never glitches.
        case (state_next)
            S_START: tx_next = 1'b0;
            S_DATA:  tx_next = shift_next[0];
            default: tx_next = 1'b1;
        endcase
    end

    // -----------------------------------------------------------------------
    // Read port
    // -----------------------------------------------------------------------
    logic        busy;
    logic [31:0] status;

    assign busy   = (state != S_IDLE);
    assign status = {16'h0000, 8'(count), 4'h0, overflow, busy, empty, full};

    assign bus.data_rd_data = rd_status ? status : '0;

endmodule

// File: tb/tb_uart_tx_mmio.sv
module tb_uart_tx_mmio;

    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam logic [31:0] STAT  = BASE + 32'd4;
    localparam int          CPB   = 4;
    localparam int          DEPTH = 16;
    localparam int          FRAME = 10 * CPB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx;

    uart_tx_mmio_if bus ();

    uart_tx_mmio #(
        .BASE_ADDR    (BASE),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .tx  (tx)
    );

    always #5 clk = ~clk;

    // One sample of the serial line per cycle, taken 1 time unit after each
    // rising edge. line[i] is the line level during cycle i.
    logic line[$];
    always @(posedge clk) begin
        #1;
        line.push_back(tx);
    end

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_bus();
        bus.data_wr      = 2'b00;
        bus.data_wr_addr = '0;
        bus.data_wr_data = '0;
    endtask

    // Called at a falling edge; drives one write that commits at the next
    // rising edge and returns at the following falling edge.
    task automatic wr_cycle(input logic [31:0] a, input logic [31:0] d);
        bus.data_wr      = 2'($urandom_range(1, 3));
        bus.data_wr_addr = a;
        bus.data_wr_data = d;
        #1;
        check("wr_hit", 64'(bus.wr_hit), 64'd1);
        @(negedge clk);
        idle_bus();
    endtask

    task automatic rd_status(input string tag, input logic [31:0] exp);
        bus.data_rd_addr = STAT;
        #1;
        check(tag, 64'(bus.data_rd_data), 64'(exp));
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Ideal 8N1 frame as per-cycle line levels: bit c is cycle c of the frame.
    function automatic logic [FRAME-1:0] frame_bits(input logic [7:0] b);
        logic [9:0]       f;
        logic [FRAME-1:0] r;
        f = {1'b1, b, 1'b0};
        for (int c = 0; c < FRAME; c++) r[c] = f[c / CPB];
        return r;
    endfunction

    task automatic check_frames(input string tag, input int start, input logic [7:0] bytes[$]);
        logic [FRAME-1:0] obs;
        for (int j = 0; j < bytes.size(); j++) begin
            for (int c = 0; c < FRAME; c++) obs[c] = line[start + j * FRAME + c];
            check($sformatf("%s_frame%0d", tag, j), 64'(obs), 64'(frame_bits(bytes[j])));
        end
    endtask

    function automatic int zeros_from(input int m);
        int z = 0;
        for (int i = m; i < line.size(); i++) if (line[i] !== 1'b1) z++;
        return z;
    endfunction

    function automatic logic [31:0] model_status(input int occ, input bit ovf, input bit busy);
        return (32'(occ) << 8) | (ovf ? 32'h8 : 32'h0) | (busy ? 32'h4 : 32'h0)
             | (occ == 0 ? 32'h2 : 32'h0) | (occ == DEPTH ? 32'h1 : 32'h0);
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         s;
        int         m;
        int         occ;
        bit         ovf;
        logic [7:0] b;
        logic [7:0] sent[$];

        idle_bus();
        bus.data_rd_addr = STAT;

        // ---------------- Reset state ----------------
        wait_cycles(2);
        rd_status("reset_status_during_rst", 32'h2);
        check("reset_rd_hit_status", 64'(bus.rd_hit), 64'd1);
        check("reset_tx", 64'(tx), 64'd1);
        rst = 1'b0;
        wait_cycles(1);
        rd_status("reset_status_after", 32'h2);
        bus.data_rd_addr = BASE + 32'd8;
        #1;
        check("rd_out_of_window_data", 64'(bus.data_rd_data), 64'd0);
        check("rd_out_of_window_hit", 64'(bus.rd_hit), 64'd0);
        bus.data_rd_addr = BASE;
        #1;
        check("rd_txdata_data", 64'(bus.data_rd_data), 64'd0);
        check("rd_txdata_hit", 64'(bus.rd_hit), 64'd1);
        wait_cycles(2);

        // ---------------- Single frame 0xA5 ----------------
        wr_cycle(BASE, 32'h0000_00A5);
        s = line.size() - 1;
        rd_status("single_after_push", model_status(1, 0, 0));
        wait_cycles(1);
        rd_status("single_popped", model_status(0, 0, 1));
        wait_cycles(39);
        rd_status("single_last_busy", model_status(0, 0, 1));
        wait_cycles(1);
        rd_status("single_done", model_status(0, 0, 0));
        check("single_idle_before", 64'(line[s]), 64'd1);
        sent = {8'hA5};
        check_frames("single", s + 1, sent);
        check("single_idle_after", 64'(line[s + FRAME + 1]), 64'd1);
        wait_cycles(3);

        // ---------------- Three back-to-back frames ----------------
        sent = {};
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom);
            sent.push_back(b);
            wr_cycle(BASE, {24'($urandom), b});
            if (i == 0) s = line.size() - 1;
        end
        rd_status("b2b_count2", model_status(2, 0, 1));
        wait_cycles(38);
        rd_status("b2b_count2_end", model_status(2, 0, 1));
        wait_cycles(1);
        rd_status("b2b_count1", model_status(1, 0, 1));
        wait_cycles(40);
        rd_status("b2b_count0", model_status(0, 0, 1));
        wait_cycles(40);
        rd_status("b2b_done", model_status(0, 0, 0));
        check_frames("b2b", s + 1, sent);
        check("b2b_idle_after", 64'(line[s + 3 * FRAME + 1]), 64'd1);
        wait_cycles(3);

        // ---------------- Overflow and capacity ----------------
        sent = {};
        occ  = 0;
        ovf  = 0;
        for (int i = 0; i < 18; i++) begin
            b = 8'($urandom);
            if (i == 1) occ--;          // transmitter takes the first byte
            if (occ < DEPTH) begin
                occ++;
                sent.push_back(b);
            end else begin
                ovf = 1;
            end
            wr_cycle(BASE, {24'h0, b});
            if (i == 0) s = line.size() - 1;
        end
        rd_status("ovf_full_status", model_status(occ, ovf, 1));
        wr_cycle(STAT, 32'h0000_0008);
        ovf = 0;
        rd_status("ovf_cleared", model_status(occ, ovf, 1));
        wait_cycles(23);
        occ--;
        rd_status("ovf_slot_freed", model_status(occ, ovf, 1));
        b = 8'($urandom);
        wr_cycle(BASE, {24'h0, b});
        occ++;
        sent.push_back(b);
        rd_status("ovf_refill", model_status(occ, ovf, 1));
        wait_cycles(679);
        rd_status("ovf_drained", model_status(0, 0, 0));
        check_frames("ovf", s + 1, sent);
        check("ovf_idle_after", 64'(line[s + sent.size() * FRAME + 1]), 64'd1);
        wait_cycles(3);

        // ---------------- Reset mid-frame ----------------
        b = 8'($urandom) & 8'hF7;
        wr_cycle(BASE, {24'h0, b});
        wr_cycle(BASE, 32'($urandom));
        wr_cycle(BASE, 32'($urandom));
        wait_cycles(16);
        check("midrst_bit3_level", 64'(tx), 64'(b[3]));
        rst = 1'b1;
        #1;
        check("midrst_async_tx", 64'(tx), 64'd1);
        rd_status("midrst_status_in_rst", 32'h2);
        wait_cycles(2);
        rst = 1'b0;
        rd_status("midrst_status_after", 32'h2);
        m = line.size();
        wait_cycles(100);
        check("midrst_line_quiet", 64'(zeros_from(m)), 64'd0);
        rd_status("midrst_status_late", 32'h2);

        // ---------------- Non-hitting writes ----------------
        bus.data_wr      = 2'b01;
        bus.data_wr_addr = BASE + 32'd12;
        bus.data_wr_data = 32'h0000_0055;
        #1;
        check("miss_addr_wr_hit", 64'(bus.wr_hit), 64'd0);
        @(negedge clk);
        bus.data_wr      = 2'b00;
        bus.data_wr_addr = BASE;
        bus.data_wr_data = 32'h0000_0055;
        #1;
        check("no_strobe_wr_hit", 64'(bus.wr_hit), 64'd0);
        @(negedge clk);
        idle_bus();
        m = line.size();
        rd_status("miss_status", 32'h2);
        wait_cycles(50);
        check("miss_line_quiet", 64'(zeros_from(m)), 64'd0);
        rd_status("miss_status_late", 32'h2);

        if (fails != 0) $display("%0d comparisons did not match", fails);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/uart_tx_mmio.md
# uart_tx_mmio

Memory-mapped UART transmitter attached to the data-memory write/read port of `riscv_core`, downstream of the MEM stage. It decodes core writes to its address window, buffers bytes in a FIFO, and serialises them as 8N1 frames on `tx`. Its combinational read port returns a status word, so firmware can poll for FIFO space and line activity. The top-level bus mux selects its `data_rd_data` whenever `rd_hit` is high.

## Interface
- `BASE_ADDR`, 32'h0000_1000: byte address of TXDATA. STATUS is at `BASE_ADDR+4`.
- `CLKS_PER_BIT`, 868: clock cycles per serial bit. Must be ≥2.
- `FIFO_DEPTH`, 16: FIFO entries. Must be a power of 2 and ≤128.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `data_rd_addr` in 32: core read address.
- `data_rd_data` out 32: status or zero (combinational).
- `rd_hit` out 1: `data_rd_addr` is `BASE_ADDR` or `BASE_ADDR+4` (combinational).
- `data_wr` in 2: write size from the core; any nonzero value is a write strobe.
- `data_wr_addr` in 32: core write address.
- `data_wr_data` in 32: core write data.
- `wr_hit` out 1: `data_wr != 0` and the address is in the window (combinational).
- `tx` out 1: serial line, idle high.

## Operation
- **Write TXDATA** (`data_wr != 0`, address `BASE_ADDR`): pushes `data_wr_data[7:0]`.
  - If the FIFO is full and no pop occurs that cycle, the byte is dropped and sticky `overflow` is set.
- **Write STATUS** (address `BASE_ADDR+4`): if `data_wr_data[3]` is 1, `overflow` is cleared. All other bits are ignored.
- **Read STATUS**:
  - bit0 full, bit1 empty, bit2 busy (FSM not IDLE), bit3 overflow.
  - bits[15:8] FIFO count. All other bits are 0.
- **Read TXDATA**, or any address outside the window: `data_rd_data` = 0.
- **FIFO**: circular buffer with read and write pointers of log2(FIFO_DEPTH) bits, wrapping modulo depth.
  - The count is a separate register of log2(FIFO_DEPTH)+1 bits.
  - Push and pop in the same cycle: both are performed and the count is unchanged. This holds when full, because the pop frees a slot.
- **Transmit FSM** states: IDLE → START → DATA → STOP.
  - A baud counter counts from CLKS_PER_BIT-1 down to 0. A 3-bit counter indexes the data bit.
  - IDLE: `tx`=1. If the FIFO is non-empty: pop into the shift register, reload the baud counter, go to START.
  - START: `tx`=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
  - DATA: `tx`=shift[0] (LSB first). Each time the baud counter expires, shift right and increment the bit index. After bit 7 expires, go to STOP.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles. On expiry, if the FIFO is non-empty, pop and go directly to START (no idle gap). Otherwise go to IDLE.
- `tx` is driven from a register and is glitch-free.

## Timing
- **Reset values**: `tx`=1, FSM IDLE, FIFO empty (count 0, both pointers 0), `overflow`=0, counters 0.
  - Combinational outputs follow their inputs during reset: STATUS reads 0x0000_0002.
- **Write latency**:
  - A byte written at edge k is in the FIFO after edge k.
  - If the FSM is idle, the pop occurs at edge k+1 and `tx` falls after edge k+1.
- **Frame length**: exactly 10·CLKS_PER_BIT cycles. Back-to-back frames are contiguous.
- **Busy**: asserted from the pop edge until the edge at which STOP exits to IDLE.
- **Status visibility**: STATUS reflects state registered at the preceding edge. A push at edge k is visible in count immediately after edge k.
- **Reset mid-frame**: `tx` goes to 1 asynchronously and all FIFO contents are discarded. After release the block sits in IDLE until a new write.
- **Capacity**: with the FSM idle, 17 consecutive single-cycle writes are all accepted (16 in the FIFO plus 1 in the shifter).

## Test plan
1. Reset → `tx`=1; read `BASE_ADDR+4` gives 0x0000_0002 with `rd_hit`=1; read `BASE_ADDR+8` gives 0 with `rd_hit`=0.
2. CLKS_PER_BIT=4, write 0xA5 at edge k → `tx` after edge k+1 is 0 for 4 cycles, then 1,0,1,0,0,1,0,1 at 4 cycles each, then 1 for 4 cycles. Busy lasts 40 cycles, after which STATUS = 0x0000_0002.
3. Write 0x01, 0x02, 0x03 on consecutive cycles → three contiguous frames totalling 120 cycles with no idle cycle between stop and start. STATUS count reads 2, then 1, then 0 as each frame starts.
4. Write 18 bytes on consecutive cycles while idle → the 18th byte is dropped. STATUS reads 0x0000_100D (count 16, overflow, busy, full). Writing 0x8 to STATUS clears bit3; a subsequent write then succeeds and the byte is transmitted in order.
5. Start a frame, assert `rst` during data bit 3 → `tx`=1 without waiting for a clock edge. After release, STATUS = 0x0000_0002 and no further frame is emitted.
6. Write 0x55 to `BASE_ADDR+12`, and drive `data_wr`=0 with `data_wr_addr`=`BASE_ADDR` → `wr_hit`=0 in both cases, no push, `tx` stays 1.
